alu_issue_wb: RTL and testbench

Sequencing and write-back stage that sits in front of and behind the combinational ALU. Accepts one operation per handshake from the decode stage, drives the ALU operand buses from registers, selects the opcode's result from the ALU's seven parallel outputs, and computes the Z/N/C/V flags. Presents the result to the register-file write port with a valid/ready handshake and holds it until accepted.

---
 rtl/alu_issue_wb_if.sv | 30 +++
 rtl/alu_issue_wb.sv | 159 +++++++++++++++
 tb/tb_alu_issue_wb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_wb_if.sv
// Decode-side issue channel and register-file write-back channel of alu_issue_wb.
// The slave modport is the stage itself; master is the decode / register-file side.
interface alu_issue_wb_if #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 3
);
  logic             issue_valid;
  logic             issue_ready;
  logic [2:0]       issue_opcode;
  logic [RD_W-1:0]  issue_rd;
  logic [WIDTH-1:0] issue_a;
  logic [WIDTH-1:0] issue_b;

  logic             wb_valid;
  logic             wb_ready;
  logic             wb_we;
  logic [RD_W-1:0]  wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             illegal_op;

  modport slave (
    input  issue_valid, issue_opcode, issue_rd, issue_a, issue_b, wb_ready,
    output issue_ready, wb_valid, wb_we, wb_rd, wb_data, illegal_op
  );

  modport master (
    output issue_valid, issue_opcode, issue_rd, issue_a, issue_b, wb_ready,
    input  issue_ready, wb_valid, wb_we, wb_rd, wb_data, illegal_op
  );
endinterface

// File: rtl/alu_issue_wb.sv
// Issue / write-back sequencer wrapped around a combinational ALU: latches one op,
// selects the ALU result, derives Z/N/C/V and hands the result to the register file.
module alu_issue_wb #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_wb_if.slave    bus,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_add,
  input  logic [WIDTH-1:0] alu_sub,
  input  logic [WIDTH-1:0] alu_and,
  input  logic [WIDTH-1:0] alu_or,
  input  logic [WIDTH-1:0] alu_xor,
  input  logic [WIDTH-1:0] alu_not,
  input  logic [WIDTH-1:0] alu_cmp,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOT  = 3'd5,
    OP_CMP  = 3'd6,
    OP_RSVD = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e           state, state_nxt;
  opcode_e          op_r;
  logic [RD_W-1:0]  rd_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] data_r;
  logic             we_r, ill_r;
  logic [3:0]       pend_r, flags_r;

  logic [WIDTH-1:0] res_c;
  logic [3:0]       pend_c;
  logic             c_add, c_sub, z_c, n_c, c_c, v_c;

  // ---------------------------------------------------------------- state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt unassigned
    // and infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.issue_valid) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      if (bus.wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Decoded from registered state only; wb_ready / issue_valid never reach an output.
  always_comb begin
    bus.issue_ready = (state == IDLE);
    bus.wb_valid    = (state == WB);
    bus.wb_we       = (state == WB) && we_r;
    bus.illegal_op  = (state == WB) && ill_r;
  end

  assign bus.wb_rd   = rd_r;
  assign bus.wb_data = data_r;
  assign alu_op1     = a_r;
  assign alu_op2     = b_r;
  assign flags       = flags_r;

  // ---------------------------------------------------------------- result select and flags
  // Carry out of the (WIDTH+1)-bit sums expressed as unsigned compares:
  // A+B carries iff A > ~B; A+~B+1 carries iff A >= B.
  assign c_add = (a_r > ~b_r);
  assign c_sub = (a_r >= b_r);

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    unique case (op_r)
      OP_ADD: begin
        res_c = alu_add;
        c_c   = c_add;
        v_c   = (a_r[MSB] == b_r[MSB]) && (alu_add[MSB] != a_r[MSB]);
      end
      OP_SUB: begin
        res_c = alu_sub;
        c_c   = c_sub;
        v_c   = (a_r[MSB] != b_r[MSB]) && (alu_sub[MSB] != a_r[MSB]);
      end
      OP_CMP: begin
        res_c = alu_cmp;
        c_c   = c_sub;
        v_c   = (a_r[MSB] != b_r[MSB]) && (alu_cmp[MSB] != a_r[MSB]);
      end
      OP_AND:  res_c = alu_and;
      OP_OR:   res_c = alu_or;
      OP_XOR:  res_c = alu_xor;
      OP_NOT:  res_c = alu_not;
      default: res_c = '0;
    endcase
    z_c    = (res_c == '0);
    n_c    = res_c[MSB];
    pend_c = (op_r == OP_RSVD) ? flags_r : {z_c, n_c, c_c, v_c};
  end

  // ---------------------------------------------------------------- datapath registers
  // Loaded only on state transitions, so everything presented in WB stays put under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= OP_ADD;
      rd_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      data_r  <= '0;
      we_r    <= 1'b0;
      ill_r   <= 1'b0;
      pend_r  <= '0;
      flags_r <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.issue_valid) begin
          op_r <= opcode_e'(bus.issue_opcode);
          rd_r <= bus.issue_rd;
          a_r  <= bus.issue_a;
          b_r  <= bus.issue_b;
        end
        EXEC: begin
          data_r <= res_c;
          we_r   <= (op_r != OP_CMP) && (op_r != OP_RSVD);
          ill_r  <= (op_r == OP_RSVD);
          pend_r <= pend_c;
        end
        WB: if (bus.wb_ready) flags_r <= pend_r;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb: stimulus pushes hand-computed results into a
// scoreboard queue, a negedge monitor pops and compares each write-back handshake.
module tb_alu_issue_wb;

  localparam int WIDTH = 16;
  localparam int RD_W  = 3;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, NOT_ = 3'd5, CMP = 3'd6, RSVD = 3'd7;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             we;
    logic             ill;
    logic [RD_W-1:0]  rd;
    logic [3:0]       flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [WIDTH-1:0] alu_op1, alu_op2;
  logic [WIDTH-1:0] alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_not, alu_cmp;
  logic [3:0]       flags;

  alu_issue_wb_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();

  alu_issue_wb #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .alu_op1 (alu_op1),
    .alu_op2 (alu_op2),
    .alu_add (alu_add),
    .alu_sub (alu_sub),
    .alu_and (alu_and),
    .alu_or  (alu_or),
    .alu_xor (alu_xor),
    .alu_not (alu_not),
    .alu_cmp (alu_cmp),
    .flags   (flags)
  );

  // Reference combinational ALU behind the stage.
  assign alu_add = alu_op1 + alu_op2;
  assign alu_sub = alu_op1 - alu_op2;
  assign alu_and = alu_op1 & alu_op2;
  assign alu_or  = alu_op1 | alu_op2;
  assign alu_xor = alu_op1 ^ alu_op2;
  assign alu_not = ~alu_op1;
  assign alu_cmp = alu_op1 - alu_op2;

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic       flag_pend = 1'b0;
  logic [3:0] flag_exp;

  always @(negedge clk) begin
    exp_t e;
    if (flag_pend) begin
      check("flags_after_commit", 32'(flags), 32'(flag_exp));
      flag_pend = 1'b0;
    end
    if (bus.wb_valid && bus.wb_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", 32'(bus.wb_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_data", 32'(bus.wb_data), 32'(e.data));
        check("wb_we", 32'(bus.wb_we), 32'(e.we));
        check("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
        if (e.we) check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
        flag_exp  = e.flags;
        flag_pend = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] data, input logic we, input logic ill,
                          input logic [RD_W-1:0] rd, input logic [3:0] fl);
    exp_t e;
    e.data = data; e.we = we; e.ill = ill; e.rd = rd; e.flags = fl;
    exp_q.push_back(e);
  endtask

  // Offers one op and returns 1 ns after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [RD_W-1:0] rd,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int budget = 50;
    while (!bus.issue_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!bus.issue_ready) check("issue_ready_timeout", 32'd0, 32'd1);
    bus.issue_valid  = 1'b1;
    bus.issue_opcode = op;
    bus.issue_rd     = rd;
    bus.issue_a      = a;
    bus.issue_b      = b;
    tick();
    bus.issue_valid  = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 50;
    while ((exp_q.size() != 0 || !bus.issue_ready) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("wb_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_wb_valid();
    int budget = 20;
    while (!bus.wb_valid && budget > 0) begin
      tick();
      budget--;
    end
    if (!bus.wb_valid) check("wb_valid_timeout", 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------- directed sequence
  initial begin
    bus.issue_valid  = 1'b0;
    bus.issue_opcode = '0;
    bus.issue_rd     = '0;
    bus.issue_a      = '0;
    bus.issue_b      = '0;
    bus.wb_ready     = 1'b1;
    #2;
    check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_we", 32'(bus.wb_we), 32'd0);
    check("rst_illegal", 32'(bus.illegal_op), 32'd0);
    check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("rst_wb_data", 32'(bus.wb_data), 32'd0);
    check("rst_alu_op1", 32'(alu_op1), 32'd0);
    check("rst_alu_op2", 32'(alu_op2), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ADD wrap to zero, with latency and ready-return checks
    push_exp(16'h0000, 1'b1, 1'b0, 3'd3, 4'b1010);
    issue(ADD, 3'd3, 16'hFFFF, 16'h0001);
    check("lat_exec_no_valid", 32'(bus.wb_valid), 32'd0);
    check("lat_exec_not_ready", 32'(bus.issue_ready), 32'd0);
    check("alu_op1_latched", 32'(alu_op1), 32'h0000FFFF);
    tick();
    check("lat_wb_valid", 32'(bus.wb_valid), 32'd1);
    tick();
    check("ready_after_hs", 32'(bus.issue_ready), 32'd1);
    check("valid_drops_after_hs", 32'(bus.wb_valid), 32'd0);
    wait_done();

    // Signed-overflow cases, compare, logic
    push_exp(16'h7FFF, 1'b1, 1'b0, 3'd1, 4'b0011);
    issue(SUB, 3'd1, 16'h8000, 16'h0001);
    wait_done();
    push_exp(16'h8000, 1'b1, 1'b0, 3'd2, 4'b0101);
    issue(ADD, 3'd2, 16'h7FFF, 16'h0001);
    wait_done();
    push_exp(16'hFFFE, 1'b0, 1'b0, 3'd4, 4'b0100);
    issue(CMP, 3'd4, 16'h0005, 16'h0007);
    wait_done();
    push_exp(16'h000F, 1'b1, 1'b0, 3'd5, 4'b0000);
    issue(AND_, 3'd5, 16'h0F0F, 16'h00FF);
    wait_done();

    // Backpressure on XOR; an issue_valid pulse during WB must be ignored
    bus.wb_ready = 1'b0;
    push_exp(16'hFFFF, 1'b1, 1'b0, 3'd6, 4'b0100);
    issue(XOR_, 3'd6, 16'hAAAA, 16'h5555);
    wait_wb_valid();
    for (int i = 0; i < 4; i++) begin
      check("bp_wb_valid", 32'(bus.wb_valid), 32'd1);
      check("bp_wb_data", 32'(bus.wb_data), 32'h0000FFFF);
      check("bp_issue_ready", 32'(bus.issue_ready), 32'd0);
      check("bp_flags_held", 32'(flags), 32'd0);
      check("bp_alu_op1", 32'(alu_op1), 32'h0000AAAA);
      if (i == 1) begin
        bus.issue_valid  = 1'b1;
        bus.issue_opcode = OR_;
        bus.issue_rd     = 3'd7;
        bus.issue_a      = 16'h1234;
        bus.issue_b      = 16'h4321;
      end else begin
        bus.issue_valid  = 1'b0;
      end
      tick();
    end
    bus.issue_valid = 1'b0;
    check("bp_op1_after_pulse", 32'(alu_op1), 32'h0000AAAA);
    bus.wb_ready = 1'b1;
    wait_done();
    repeat (4) tick();

    // Reserved opcode after a flag-setting op: flags stay {0,1,0,0}
    push_exp(16'h0000, 1'b0, 1'b1, 3'd2, 4'b0100);
    issue(RSVD, 3'd2, 16'h1111, 16'h2222);
    wait_done();

    // Reset during WB of NOT discards the op
    bus.wb_ready = 1'b0;
    issue(NOT_, 3'd1, 16'h00FF, 16'h0000);
    wait_wb_valid();
    check("not_wb_data", 32'(bus.wb_data), 32'h0000FF00);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("mid_rst_wb_we", 32'(bus.wb_we), 32'd0);
    check("mid_rst_flags", 32'(flags), 32'd0);
    check("mid_rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    repeat (6) tick();
    check("post_rst_flags", 32'(flags), 32'd0);

    // Still alive after reset: OR
    push_exp(16'h0FF0, 1'b1, 1'b0, 3'd7, 4'b0000);
    issue(OR_, 3'd7, 16'h00F0, 16'h0F00);
    wait_done();
    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
